fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 8-bit computer, sitting directly upstream of the program/data memory. It owns the program counter and the memory address register, and drives the memory address port. It captures the memory's read data into an instruction register and hands each fetched instruction to the control/execute stage over a valid/ready handshake. It also accepts jump redirects from that stage.

## Interface
Parameters:
- DATA_WIDTH, 8, instruction/memory word width
- ADDR_WIDTH, 4, program counter and memory address width (16 words)
- RESET_PC, 0, program counter value after reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- run  in  1  fetch enable; fetching starts/continues while high
- mem_address  out  ADDR_WIDTH  drives memory address port; equals registered MAR
- mem_data  in  DATA_WIDTH  memory data_out; combinational read of mem_address
- instr  out  DATA_WIDTH  instruction register
- instr_pc  out  ADDR_WIDTH  address instr was fetched from
- instr_valid  out  1  instr/instr_pc hold an unconsumed instruction
- instr_ready  in  1  consumer accepts instr on a cycle where instr_valid is also high
- jump  in  1  redirect request, one-cycle pulse
- jump_target  in  ADDR_WIDTH  new PC when jump is high
- pc  out  ADDR_WIDTH  current program counter (next address to fetch)

The block never writes memory. Memory write/address muxing for loading belongs to another block.

## Operation
- States: IDLE, ADDR, LATCH, HOLD.
- Reset (rst_n low at an edge): state=IDLE, pc=RESET_PC, mar=RESET_PC, instr=0, instr_pc=0, instr_valid=0. Reset overrides jump/run and aborts any fetch in flight.
- IDLE: if run then go to ADDR, else stay.
- ADDR: mar<=pc; go to LATCH.
- LATCH: instr<=mem_data; instr_pc<=mar; pc<=pc+1 modulo 2^ADDR_WIDTH; instr_valid<=1; go to HOLD.
- HOLD: instr, instr_pc and instr_valid are stable. On instr_ready: instr_valid<=0 and go to ADDR if run, else IDLE. Without instr_ready: stay.
- Jump (highest priority after reset), in any state: pc<=jump_target, instr_valid<=0, next state=ADDR if run else IDLE. An in-flight fetch is discarded with no instr_valid pulse and no pc increment.
- Jump with instr_valid and instr_ready both high in the same cycle: the handshake counts as completed, because the consumer owns that instruction, and the jump is then applied as above.
- run dropped mid-fetch (ADDR/LATCH/HOLD): the current fetch completes and is held until accepted, then the block goes to IDLE. pc stays pointing to the next instruction.
- Wrap-around: pc at 2^ADDR_WIDTH-1 increments to 0. No flag is raised.
- mem_address is always the registered mar and never a combinational pc.

## Timing
- From IDLE with run=1 sampled at edge E: ADDR after E, mar valid after E+1, instr_valid=1 after E+2.
- Steady state with instr_ready tied high: one instruction per 3 cycles (ADDR, LATCH, HOLD).
- Back-pressure: HOLD may last any number of cycles, and outputs are unchanged during it.
- Jump at edge J: mar=jump_target after J+1 (if run), and the target instruction is valid after J+2.
- mem_data is sampled only at the LATCH edge, one cycle after mar settles.

## Test plan
- Memory preloaded with data i+1 at address i (0..15), reset, then run=1 with instr_ready=1 -> instr 0x01..0x10 with instr_pc 0..15, a valid pulse every 3 cycles, then wrap to instr_pc=0, instr=0x01.
- Back-pressure: hold instr_ready=0 for 5 cycles at instr_pc=2 -> instr=0x03 and instr_valid stable for all 5 cycles, pc=3. Release -> next instr=0x04.
- Jump to 0xC during LATCH of address 5 -> no valid for address 5, next instr_pc=12, instr=0x0D, pc=13 after capture.
- Jump to 0x7 coincident with accepting instr_pc=3 -> instr_pc=3 counts as accepted, next instr_pc=7.
- Drop run while in ADDR for address 9 -> instr_pc=9 is delivered, then IDLE with pc=10. Reassert run -> resumes at 10.
- rst_n low mid-HOLD with RESET_PC=4 -> instr_valid=0, instr=0, pc=4 after the edge. First instr_pc after run is 4.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: memory address/data port, instruction handshake toward execute,
// and jump redirect/run control coming back from execute.
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  run;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  jump;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic [ADDR_WIDTH-1:0] pc;

    modport master (
        input  run, mem_data, instr_ready, jump, jump_target,
        output mem_address, instr, instr_pc, instr_valid, pc
    );

    modport slave (
        output run, mem_data, instr_ready, jump, jump_target,
        input  mem_address, instr, instr_pc, instr_valid, pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and MAR, captures memory data into the instruction
// register and offers it downstream over valid/ready; accepts jump redirects.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, LATCH, HOLD} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            mar_q      <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mar_q      <= mar_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mar_d      = mar_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        // A jump wins over everything; a coincident handshake is simply absorbed
        // because the consumer already took the instruction this cycle.
        if (bus.jump) begin
            pc_d    = bus.jump_target;
            valid_d = 1'b0;
            state_d = bus.run ? ADDR : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.run) state_d = ADDR;
                end
                ADDR: begin
                    mar_d   = pc_q;
                    state_d = LATCH;
                end
                LATCH: begin
                    instr_d    = bus.mem_data;
                    instr_pc_d = mar_q;
                    pc_d       = pc_q + ADDR_WIDTH'(1);
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        valid_d = 1'b0;
                        state_d = bus.run ? ADDR : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.mem_address = mar_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random run/ready/jump/reset
// traffic, all compared every cycle against an event-scheduled reference model.
module tb_fetch_unit;
    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int RST_PC = 4;

    logic clk;
    logic rst_n;
    logic [DW-1:0] mem [16];

    fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fetch_unit #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RESET_PC  (AW'(RST_PC))
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    assign bus.mem_data = mem[bus.mem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: a fetch is a pair of scheduled events (MAR load, then capture)
    // identified by the edge number they fire on; -1 means nothing scheduled.
    logic [AW-1:0] m_pc, m_mar, m_ipc;
    logic [DW-1:0] m_instr;
    logic          m_valid;
    int            m_mar_edge = -1;
    int            m_cap_edge = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        int n;
        n = cyc;
        if (!rst_n) begin
            m_pc = AW'(RST_PC); m_mar = AW'(RST_PC); m_instr = '0; m_ipc = '0;
            m_valid = 1'b0; m_mar_edge = -1; m_cap_edge = -1;
        end else if (bus.jump) begin
            m_valid    = 1'b0;
            m_pc       = bus.jump_target;
            m_cap_edge = -1;
            m_mar_edge = bus.run ? n + 1 : -1;
        end else if (m_mar_edge == n) begin
            m_mar      = m_pc;
            m_mar_edge = -1;
            m_cap_edge = n + 1;
        end else if (m_cap_edge == n) begin
            m_instr    = mem[m_mar];
            m_ipc      = m_mar;
            m_pc       = AW'((int'(m_pc) + 1) % 16);
            m_valid    = 1'b1;
            m_cap_edge = -1;
        end else if (m_valid) begin
            if (bus.instr_ready) begin
                m_valid = 1'b0;
                if (bus.run) m_mar_edge = n + 1;
            end
        end else if (bus.run) begin
            m_mar_edge = n + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("mem_address", 32'(bus.mem_address), 32'(m_mar));
        check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        check("instr",       32'(bus.instr),       32'(m_instr));
        check("instr_pc",    32'(bus.instr_pc),    32'(m_ipc));
        check("pc",          32'(bus.pc),          32'(m_pc));
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60; i++) begin
            if (m_valid) break;
            tick();
        end
        check("wait_valid_timeout", 32'(bus.instr_valid), 32'd1);
    endtask

    int  k, last_cyc;
    bit  saw5;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'(i + 1);
        rst_n = 1'b0; bus.run = 1'b0; bus.instr_ready = 1'b0;
        bus.jump = 1'b0; bus.jump_target = '0;

        // Reset state
        tick(); tick();
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_pc", 32'(bus.pc), 32'(RST_PC));
        check("rst_mar", 32'(bus.mem_address), 32'(RST_PC));

        // Point at address 0 while idle, then stream all 16 words plus wrap
        rst_n = 1'b1; bus.jump = 1'b1; bus.jump_target = '0;
        tick();
        bus.jump = 1'b0;
        check("idle_after_jump_pc", 32'(bus.pc), 32'd0);
        bus.run = 1'b1; bus.instr_ready = 1'b1;
        k = 0; last_cyc = 0;
        for (int i = 0; i < 70 && k < 17; i++) begin
            tick();
            if (bus.instr_valid) begin
                check("stream_ipc", 32'(bus.instr_pc), 32'(k % 16));
                check("stream_instr", 32'(bus.instr), 32'(k % 16 + 1));
                if (k > 0) check("stream_spacing", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                k++;
            end
        end
        check("stream_count", 32'(k), 32'd17);

        // Back-pressure at instr_pc=2
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_valid && m_ipc == 2) break;
        end
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_instr", 32'(bus.instr), 32'h03);
            check("bp_valid", 32'(bus.instr_valid), 32'd1);
            check("bp_pc", 32'(bus.pc), 32'd3);
        end
        bus.instr_ready = 1'b1;
        tick();
        wait_valid();
        check("bp_next_instr", 32'(bus.instr), 32'h04);

        // Jump to 0xC while address 5 is being captured
        for (int i = 0; i < 40; i++) begin
            if (m_cap_edge == cyc && m_mar == 5) break;
            tick();
        end
        bus.jump = 1'b1; bus.jump_target = 4'hC;
        tick();
        bus.jump = 1'b0;
        saw5 = 1'b0;
        for (int i = 0; i < 10 && !m_valid; i++) begin
            tick();
            if (bus.instr_valid && bus.instr_pc == 5) saw5 = 1'b1;
        end
        check("jmp_no_addr5", 32'(saw5), 32'd0);
        check("jmp_ipc", 32'(bus.instr_pc), 32'd12);
        check("jmp_instr", 32'(bus.instr), 32'h0D);
        check("jmp_pc", 32'(bus.pc), 32'd13);

        // Jump coincident with acceptance of instr_pc=3
        for (int i = 0; i < 60; i++) begin
            tick();
            if (m_valid && m_ipc == 3) break;
        end
        check("acc3_ipc", 32'(bus.instr_pc), 32'd3);
        bus.jump = 1'b1; bus.jump_target = 4'h7;
        tick();
        bus.jump = 1'b0;
        check("acc3_cleared", 32'(bus.instr_valid), 32'd0);
        wait_valid();
        check("acc3_next_ipc", 32'(bus.instr_pc), 32'd7);
        check("acc3_next_instr", 32'(bus.instr), 32'h08);

        // Drop run while in ADDR for address 9
        for (int i = 0; i < 40; i++) begin
            if (m_mar_edge == cyc && m_pc == 9) break;
            tick();
        end
        bus.run = 1'b0;
        tick();
        wait_valid();
        check("drop_ipc", 32'(bus.instr_pc), 32'd9);
        for (int i = 0; i < 4; i++) tick();
        check("drop_idle_valid", 32'(bus.instr_valid), 32'd0);
        check("drop_idle_pc", 32'(bus.pc), 32'd10);
        bus.run = 1'b1;
        wait_valid();
        check("resume_ipc", 32'(bus.instr_pc), 32'd10);
        check("resume_instr", 32'(bus.instr), 32'h0B);

        // Reset in the middle of HOLD
        bus.instr_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("midrst_valid", 32'(bus.instr_valid), 32'd0);
        check("midrst_instr", 32'(bus.instr), 32'd0);
        check("midrst_pc", 32'(bus.pc), 32'(RST_PC));
        rst_n = 1'b1; bus.instr_ready = 1'b1;
        wait_valid();
        check("postrst_ipc", 32'(bus.instr_pc), 32'(RST_PC));
        check("postrst_instr", 32'(bus.instr), 32'(RST_PC + 1));

        // Random traffic over random memory contents
        for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 500; i++) begin
            bus.run         = ($urandom % 8) != 0;
            bus.instr_ready = ($urandom % 3) != 0;
            bus.jump        = ($urandom % 12) == 0;
            bus.jump_target = AW'($urandom);
            rst_n           = ($urandom % 80) != 0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
